// File: rtl/memory_arbiter_pkg.sv
// Shared types and sizing for the two-client off-chip memory arbiter.
package memory_arbiter_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BEAT_W      = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    // One-hot owner code for a given arbiter state.
    function automatic logic [1:0] grant_of(arb_state_t s);
        case (s)
            SERVE_I: grant_of = GRANT_I;
            SERVE_D: grant_of = GRANT_D;
            default: grant_of = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/memory_arbiter_beat_counter.sv
// Counts valid fill beats of the current block; flags the last word.
module beat_counter
    import memory_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    logic [BEAT_W-1:0] count_reg;

    // Clear wins over enable so an ending fill always restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + BEAT_W'(1);
        end
    end

    assign terminal = (count_reg == LAST_BEAT);

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the icache and
// dcache miss engines; an owner keeps the port for a full 8-word block fill
// or until it drops its busy request.
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_busy,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_busy,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic [DATA_W-1:0] icache_data,
    output logic [DATA_W-1:0] dcache_data,
    output logic              icache_data_valid,
    output logic              dcache_data_valid,
    output logic [1:0]        grant,
    output logic              stray_valid
);

    arb_state_t state_reg, state_next;
    logic       last_d_reg;     // 1: dcache was the most recent owner
    logic       stray_reg;
    logic       owner_busy;
    logic       owner_valid;
    logic       fill_end;
    logic       beat_last;

    assign owner_busy  = (state_reg == SERVE_I) ? icache_busy :
                         (state_reg == SERVE_D) ? dcache_busy : 1'b0;
    assign owner_valid = (state_reg != IDLE) && mem_data_valid_in;
    // A fill ends on its last beat or when the owner abandons the miss.
    assign fill_end    = (state_reg != IDLE) &&
                         (!owner_busy || (owner_valid && beat_last));

    beat_counter u_beat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (owner_valid),
        .clear    ((state_reg == IDLE) || fill_end),
        .terminal (beat_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Round-robin history (updated on grant) and sticky stray-beat flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_reg <= 1'b0;
            stray_reg  <= 1'b0;
        end else begin
            if (state_reg == IDLE && state_next == SERVE_D) last_d_reg <= 1'b1;
            if (state_reg == IDLE && state_next == SERVE_I) last_d_reg <= 1'b0;
            if (state_reg == IDLE && mem_data_valid_in)     stray_reg  <= 1'b1;
        end
    end

    // Next-state: grant from IDLE only, so the other side waits for IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (icache_busy && dcache_busy) begin
                    state_next = last_d_reg ? SERVE_I : SERVE_D;
                end else if (icache_busy) begin
                    state_next = SERVE_I;
                end else if (dcache_busy) begin
                    state_next = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (fill_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: owner's address and valid pass straight through; data is shared.
    always_comb begin
        grant             = grant_of(state_reg);
        mem_enable        = 1'b0;
        mem_addr          = '0;
        icache_data_valid = 1'b0;
        dcache_data_valid = 1'b0;
        icache_data       = mem_data_in;
        dcache_data       = mem_data_in;
        case (state_reg)
            SERVE_I: begin
                mem_enable        = 1'b1;
                mem_addr          = icache_addr;
                icache_data_valid = mem_data_valid_in;
            end
            SERVE_D: begin
                mem_enable        = 1'b1;
                mem_addr          = dcache_addr;
                dcache_data_valid = mem_data_valid_in;
            end
            default: ;
        endcase
    end

    assign stray_valid = stray_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: fixed vector table, directed
// multi-cycle sequences and randomized traffic against a transaction model.
module tb_memory_arbiter;

    localparam logic [15:0] IA = 16'h4440;
    localparam logic [15:0] DA = 16'h1230;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_busy = 1'b0;
    logic [15:0] icache_addr = 16'h0;
    logic        dcache_busy = 1'b0;
    logic [15:0] dcache_addr = 16'h0;
    logic [15:0] mem_data_in = 16'h0;
    logic        mem_data_valid_in = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic [15:0] icache_data;
    logic [15:0] dcache_data;
    logic        icache_data_valid;
    logic        dcache_data_valid;
    logic [1:0]  grant;
    logic        stray_valid;

    memory_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .icache_busy       (icache_busy),
        .icache_addr       (icache_addr),
        .dcache_busy       (dcache_busy),
        .dcache_addr       (dcache_addr),
        .mem_data_in       (mem_data_in),
        .mem_data_valid_in (mem_data_valid_in),
        .mem_addr          (mem_addr),
        .mem_enable        (mem_enable),
        .icache_data       (icache_data),
        .dcache_data       (dcache_data),
        .icache_data_valid (icache_data_valid),
        .dcache_data_valid (dcache_data_valid),
        .grant             (grant),
        .stray_valid       (stray_valid)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // {grant, enable, addr, ivalid, dvalid, idata, ddata, stray}
    function automatic logic [63:0] pack_out();
        return {10'b0, grant, mem_enable, mem_addr, icache_data_valid,
                dcache_data_valid, icache_data, dcache_data, stray_valid};
    endfunction

    // ---------------- transaction-level reference model ----------------
    int   m_owner;     // 0 none, 1 icache, 2 dcache
    int   m_beats;     // words delivered in the current fill
    bit   m_last_i;    // icache was the most recent owner
    bit   m_stray;

    function automatic void model_reset();
        m_owner  = 0;
        m_beats  = 0;
        m_last_i = 1'b1;
        m_stray  = 1'b0;
    endfunction

    function automatic logic [63:0] model_out();
        logic [1:0]  g;
        logic        en;
        logic [15:0] a;
        logic        iv, dv;
        g  = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        en = (m_owner != 0);
        a  = (m_owner == 1) ? icache_addr : (m_owner == 2) ? dcache_addr : 16'h0;
        iv = (m_owner == 1) && mem_data_valid_in;
        dv = (m_owner == 2) && mem_data_valid_in;
        return {10'b0, g, en, a, iv, dv, mem_data_in, mem_data_in, m_stray};
    endfunction

    function automatic void model_update();
        bit ob;
        if (m_owner == 0) begin
            if (mem_data_valid_in) m_stray = 1'b1;
            if (icache_busy && dcache_busy) m_owner = m_last_i ? 2 : 1;
            else if (icache_busy)           m_owner = 1;
            else if (dcache_busy)           m_owner = 2;
            if (m_owner != 0) begin
                m_last_i = (m_owner == 1);
                m_beats  = 0;
            end
        end else begin
            ob = (m_owner == 1) ? icache_busy : dcache_busy;
            if (!ob) begin
                m_owner = 0;
            end else if (mem_data_valid_in) begin
                m_beats++;
                if (m_beats == 8) m_owner = 0;
            end
        end
    endfunction

    // Called at posedge+1 with inputs set; checks, then advances one clock.
    task automatic step(string name);
        #1;
        chk(name, pack_out(), model_out());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic release_reset();
        icache_busy = 1'b0;
        dcache_busy = 1'b0;
        mem_data_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        icache_busy = 1'b0;
        dcache_busy = 1'b0;
        mem_data_valid_in = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_state", pack_out(), model_out());
        release_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        ib, db, v;
        logic [15:0] d;
        logic [1:0]  g;
        logic        en;
        logic [15:0] a;
        logic        iv, dv;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic ib, logic db, logic v, logic [15:0] d,
                                logic [1:0] g, logic en, logic [15:0] a, logic iv, logic dv);
        vec_t r;
        r.rst = rst; r.ib = ib; r.db = db; r.v = v; r.d = d;
        r.g = g; r.en = en; r.a = a; r.iv = iv; r.dv = dv;
        vecs.push_back(r);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g[4];
        logic [63:0] exp_vec;
        icache_addr = IA;
        dcache_addr = DA;

        // dcache alone: 8-word fill
        add(1, 0, 1, 0, 16'h0, 2'b00, 0, 16'h0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(0, 0, 1, 1, 16'hA000 + 16'(k), 2'b10, 1, DA, 0, 1);
        add(0, 0, 0, 0, 16'h0, 2'b00, 0, 16'h0, 0, 0);
        // tie after reset: dcache first, then icache
        add(1, 1, 1, 0, 16'h0, 2'b00, 0, 16'h0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(0, 1, 1, 1, 16'hB000 + 16'(k), 2'b10, 1, DA, 0, 1);
        add(0, 1, 0, 0, 16'h0,    2'b00, 0, 16'h0, 0, 0);
        add(0, 1, 0, 0, 16'h0,    2'b01, 1, IA,    0, 0);
        add(0, 1, 0, 1, 16'hC000, 2'b01, 1, IA,    1, 0);
        add(0, 0, 0, 0, 16'h0,    2'b01, 1, IA,    0, 0);
        add(0, 0, 0, 0, 16'h0,    2'b00, 0, 16'h0, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) apply_reset();
            icache_addr = IA;
            dcache_addr = DA;
            icache_busy = vecs[i].ib;
            dcache_busy = vecs[i].db;
            mem_data_valid_in = vecs[i].v;
            mem_data_in = vecs[i].d;
            #1;
            exp_vec = {10'b0, vecs[i].g, vecs[i].en, vecs[i].a, vecs[i].iv, vecs[i].dv,
                       vecs[i].d, vecs[i].d, 1'b0};
            chk($sformatf("vec%0d", i), pack_out(), exp_vec);
            $display("vec %0d: grant=%b en=%b addr=%h iv=%b dv=%b", i, grant, mem_enable,
                     mem_addr, icache_data_valid, dcache_data_valid);
            @(posedge clk);
            #1;
        end

        // Back-to-back ties alternate D, I, D, I
        apply_reset();
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        icache_busy = 1'b1;
        dcache_busy = 1'b1;
        for (int f = 0; f < 4; f++) begin
            mem_data_valid_in = 1'b0;
            for (int w = 0; w < 4 && grant == 2'b00; w++) step("rr_wait");
            chk($sformatf("rr_grant%0d", f), 64'(grant), 64'(exp_g[f]));
            for (int b = 0; b < 8; b++) begin
                mem_data_valid_in = 1'b1;
                mem_data_in = 16'($urandom);
                step("rr_beat");
            end
        end
        $display("round-robin sequence done");

        // Aborted icache fill after 3 beats, then a full fill from zero
        apply_reset();
        icache_busy = 1'b1;
        step("abort_idle");
        chk("abort_grant", 64'(grant), 64'(2'b01));
        for (int b = 0; b < 3; b++) begin
            mem_data_valid_in = 1'b1;
            step("abort_beat");
        end
        icache_busy = 1'b0;
        mem_data_valid_in = 1'b0;
        step("abort_drop");
        chk("abort_idle_after", 64'(grant), 64'(2'b00));
        icache_busy = 1'b1;
        step("refill_idle");
        for (int b = 0; b < 7; b++) begin
            mem_data_valid_in = 1'b1;
            step("refill_beat");
        end
        chk("refill_7_held", 64'(grant), 64'(2'b01));
        step("refill_beat8");
        chk("refill_8_done", 64'(grant), 64'(2'b00));
        $display("abort sequence done");

        // Stray beat in IDLE is dropped and latched until reset
        apply_reset();
        mem_data_valid_in = 1'b1;
        step("stray_beat");
        mem_data_valid_in = 1'b0;
        for (int c = 0; c < 3; c++) step("stray_hold");
        chk("stray_sticky", 64'(stray_valid), 64'(1'b1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("stray_cleared", 64'(stray_valid), 64'(1'b0));
        release_reset();
        $display("stray sequence done");

        // Asynchronous reset mid dcache fill
        apply_reset();
        dcache_busy = 1'b1;
        step("ar_idle");
        for (int b = 0; b < 5; b++) begin
            mem_data_valid_in = 1'b1;
            step("ar_beat");
        end
        mem_data_valid_in = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_no_edge", {44'b0, grant, mem_enable, mem_addr, icache_data_valid, dcache_data_valid},
            64'h0);
        model_reset();
        release_reset();
        dcache_busy = 1'b1;
        step("ar_re_idle");
        for (int b = 0; b < 7; b++) begin
            mem_data_valid_in = 1'b1;
            step("ar_refill");
        end
        chk("ar_refill_7_held", 64'(grant), 64'(2'b10));
        dcache_busy = 1'b1;
        step("ar_refill8");
        chk("ar_refill_8_done", 64'(grant), 64'(2'b00));
        $display("async reset sequence done");

        // Randomized traffic against the model
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) icache_busy = ~icache_busy;
            if ($urandom_range(0, 7) == 0) dcache_busy = ~dcache_busy;
            mem_data_valid_in = ($urandom_range(0, 2) != 0);
            mem_data_in = 16'($urandom);
            icache_addr = 16'($urandom);
            dcache_addr = 16'($urandom);
            step($sformatf("rand%0d", c));
        end
        $display("random traffic done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
